// File: rtl/pwm_capture_pkg.sv
// pwm_capture_pkg
// Shared definitions for the PWM capture block.
//   DEF_NB_CH      default number of capture channels
//   DEF_RESOLUTION default counter/result width in bits
//   CNT_MAX        full-scale counter value at the default resolution
//   ch_result_t    one channel's committed result {ton, period, valid, stuck}
//                  at the default resolution
package pwm_capture_pkg;

    localparam int DEF_NB_CH      = 24;
    localparam int DEF_RESOLUTION = 10;
    localparam logic [DEF_RESOLUTION-1:0] CNT_MAX = '1;

    typedef struct packed {
        logic [DEF_RESOLUTION-1:0] ton;
        logic [DEF_RESOLUTION-1:0] period;
        logic                      valid;
        logic                      stuck;
    } ch_result_t;

endpackage

// File: rtl/pwm_capture_ch.sv
// pwm_capture_ch
// One capture channel: 3-stage synchronizer, edge detect, saturating cycle
// counter, armed / pending-high-time logic and the committed result registers.
// Optional feature macro: PWM_CAPTURE_TIMEOUT_EN (commit a "stuck" result
// once per stall when the counter saturates without a rising edge).
// Ports:
//   clk     system clock
//   rst_n   synchronous active-low reset
//   pwm_in  asynchronous PWM input
//   ton     committed high time in cycles
//   period  committed period in cycles
//   valid   at least one measurement committed
//   stuck   last commit came from the timeout path (0 when feature disabled)
//   commit  one-cycle pulse: the result registers update at this edge
module pwm_capture_ch
    import pwm_capture_pkg::*;
#(
    parameter int RESOLUTION = DEF_RESOLUTION
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pwm_in,
    output logic [RESOLUTION-1:0] ton,
    output logic [RESOLUTION-1:0] period,
    output logic                  valid,
    output logic                  stuck,
    output logic                  commit
);

    localparam logic [RESOLUTION-1:0] FULL = '1;

    logic                  s1_reg, s2_reg, s3_reg;
    logic                  rise, fall;
    logic [RESOLUTION-1:0] cnt_reg, cnt_next;
    logic [RESOLUTION-1:0] ton_pend_reg;
    logic [RESOLUTION-1:0] ton_reg, period_reg;
    logic                  armed_reg, valid_reg;
    logic                  timeout;

    assign rise = s2_reg & ~s3_reg;
    assign fall = ~s2_reg & s3_reg;

    // Counter restarts at 1 on the rise cycle so that on the next rise it
    // holds exactly the number of cycles elapsed; it sticks at full scale.
    assign cnt_next = rise              ? RESOLUTION'(1) :
                      (cnt_reg == FULL) ? FULL           :
                                          cnt_reg + RESOLUTION'(1);

`ifdef PWM_CAPTURE_TIMEOUT_EN
    logic stuck_reg;

    // Disarming on the timeout commit guarantees a single commit per stall.
    assign timeout = armed_reg & ~rise & (cnt_reg == FULL);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stuck_reg <= 1'b0;
        end else if (rise && armed_reg) begin
            stuck_reg <= 1'b0;
        end else if (timeout) begin
            stuck_reg <= 1'b1;
        end
    end

    assign stuck = stuck_reg;
`else
    assign timeout = 1'b0;
    assign stuck   = 1'b0;
`endif

    assign commit = (rise & armed_reg) | timeout;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_reg       <= 1'b0;
            s2_reg       <= 1'b0;
            s3_reg       <= 1'b0;
            cnt_reg      <= '0;
            ton_pend_reg <= '0;
            ton_reg      <= '0;
            period_reg   <= '0;
            armed_reg    <= 1'b0;
            valid_reg    <= 1'b0;
        end else begin
            s1_reg  <= pwm_in;
            s2_reg  <= s1_reg;
            s3_reg  <= s2_reg;
            cnt_reg <= cnt_next;

            if (fall) begin
                ton_pend_reg <= cnt_reg;
            end

            if (rise) begin
                // The first rise after reset (or after a timeout) only arms.
                armed_reg <= 1'b1;
                if (armed_reg) begin
                    ton_reg    <= ton_pend_reg;
                    period_reg <= cnt_reg;
                    valid_reg  <= 1'b1;
                end
            end else if (timeout) begin
                ton_reg    <= s2_reg ? FULL : '0;
                period_reg <= FULL;
                valid_reg  <= 1'b1;
                armed_reg  <= 1'b0;
            end
        end
    end

    assign ton    = ton_reg;
    assign period = period_reg;
    assign valid  = valid_reg;

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture
// Multi-channel PWM capture: measures high time and period of NB_CH
// asynchronous PWM inputs in ClkIn cycles; results are read one channel at a
// time through registered outputs.
// Optional feature macro: PWM_CAPTURE_TIMEOUT_EN (see pwm_capture_ch).
// Ports:
//   ClkIn      system clock
//   nReset     synchronous active-low reset
//   PWMin      asynchronous PWM inputs, one per channel
//   Sel        channel to read
//   RdStrobe   one-cycle read request for channel Sel
//   TonOut     high time of the read channel
//   PeriodOut  period of the read channel
//   Valid      read channel has committed at least one measurement
//   Stuck      read channel's last commit came from timeout
//   NewFlags   per channel: a commit occurred since the last read
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int NB_CH      = DEF_NB_CH,
    parameter int RESOLUTION = DEF_RESOLUTION,
    parameter int SEL_W      = $clog2(NB_CH)
) (
    input  logic                  ClkIn,
    input  logic                  nReset,
    input  logic [NB_CH-1:0]      PWMin,
    input  logic [SEL_W-1:0]      Sel,
    input  logic                  RdStrobe,
    output logic [RESOLUTION-1:0] TonOut,
    output logic [RESOLUTION-1:0] PeriodOut,
    output logic                  Valid,
    output logic                  Stuck,
    output logic [NB_CH-1:0]      NewFlags
);

    logic [RESOLUTION-1:0] ton_arr    [NB_CH];
    logic [RESOLUTION-1:0] period_arr [NB_CH];
    logic [NB_CH-1:0]      valid_vec, stuck_vec, commit_vec;
    logic [NB_CH-1:0]      rd_clear;
    logic [NB_CH-1:0]      new_flags_reg, new_flags_next;
    logic                  sel_ok;

    logic [RESOLUTION-1:0] ton_out_reg, period_out_reg;
    logic                  valid_out_reg, stuck_out_reg;

    assign sel_ok = ({1'b0, Sel} < (SEL_W+1)'(NB_CH));

    always_comb begin
        rd_clear = '0;
        if (RdStrobe && sel_ok) begin
            rd_clear[Sel] = 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < NB_CH; gi++) begin : g_ch
            pwm_capture_ch #(
                .RESOLUTION (RESOLUTION)
            ) u_ch (
                .clk    (ClkIn),
                .rst_n  (nReset),
                .pwm_in (PWMin[gi]),
                .ton    (ton_arr[gi]),
                .period (period_arr[gi]),
                .valid  (valid_vec[gi]),
                .stuck  (stuck_vec[gi]),
                .commit (commit_vec[gi])
            );

            // A commit in the same cycle as a read of this channel wins.
            assign new_flags_next[gi] = commit_vec[gi] |
                                        (new_flags_reg[gi] & ~rd_clear[gi]);
        end
    endgenerate

    // Reads sample the channel registers before this edge's commit, so a
    // simultaneous commit shows up on the following read.
    always_ff @(posedge ClkIn) begin
        if (!nReset) begin
            ton_out_reg    <= '0;
            period_out_reg <= '0;
            valid_out_reg  <= 1'b0;
            stuck_out_reg  <= 1'b0;
            new_flags_reg  <= '0;
        end else begin
            new_flags_reg <= new_flags_next;
            if (RdStrobe) begin
                if (sel_ok) begin
                    ton_out_reg    <= ton_arr[Sel];
                    period_out_reg <= period_arr[Sel];
                    valid_out_reg  <= valid_vec[Sel];
                    stuck_out_reg  <= stuck_vec[Sel];
                end else begin
                    ton_out_reg    <= '0;
                    period_out_reg <= '0;
                    valid_out_reg  <= 1'b0;
                    stuck_out_reg  <= 1'b0;
                end
            end
        end
    end

    assign TonOut    = ton_out_reg;
    assign PeriodOut = period_out_reg;
    assign Valid     = valid_out_reg;
    assign Stuck     = stuck_out_reg;
    assign NewFlags  = new_flags_reg;

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture
// Directed self-checking bench for pwm_capture at NB_CH=24, RESOLUTION=10.
// Expectations follow PWM_CAPTURE_TIMEOUT_EN when it is defined.
module tb_pwm_capture;
    import pwm_capture_pkg::*;

    localparam int NB_CH = 24;
    localparam int RES   = 10;
    localparam int SEL_W = 5;

    logic                 clk = 1'b0;
    logic                 n_reset = 1'b0;
    logic [NB_CH-1:0]     pwm = '0;
    logic [SEL_W-1:0]     sel = '0;
    logic                 rd = 1'b0;
    logic [RES-1:0]       ton_out, period_out;
    logic                 valid, stuck;
    logic [NB_CH-1:0]     new_flags;

    int checks = 0;
    int errors = 0;

    pwm_capture #(
        .NB_CH      (NB_CH),
        .RESOLUTION (RES),
        .SEL_W      (SEL_W)
    ) dut (
        .ClkIn     (clk),
        .nReset    (n_reset),
        .PWMin     (pwm),
        .Sel       (sel),
        .RdStrobe  (rd),
        .TonOut    (ton_out),
        .PeriodOut (period_out),
        .Valid     (valid),
        .Stuck     (stuck),
        .NewFlags  (new_flags)
    );

    always #5 clk = ~clk;

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_read(input int ch);
        sel = SEL_W'(ch);
        rd  = 1'b1;
        step(1);
        rd  = 1'b0;
        $display("read ch=%0d ton=%0d period=%0d valid=%0b stuck=%0b flags=%06h",
                 ch, ton_out, period_out, valid, stuck, new_flags);
    endtask

    task automatic test_reset();
        n_reset = 1'b0;
        step(3);
        checks++; if (ton_out !== 10'd0) begin errors++; $display("FAIL reset_ton: got %0d expected 0", ton_out); end
        checks++; if (period_out !== 10'd0) begin errors++; $display("FAIL reset_period: got %0d expected 0", period_out); end
        checks++; if (valid !== 1'b0 || stuck !== 1'b0) begin errors++; $display("FAIL reset_flags: got valid=%0b stuck=%0b expected 0 0", valid, stuck); end
        checks++; if (new_flags !== 24'h0) begin errors++; $display("FAIL reset_newflags: got %06h expected 000000", new_flags); end
        n_reset = 1'b1;
        step(2);
    endtask

    task automatic test_unarmed();
        do_read(5);
        checks++; if (ton_out !== 10'd0 || period_out !== 10'd0) begin errors++; $display("FAIL unarmed_zero: got ton=%0d period=%0d expected 0 0", ton_out, period_out); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL unarmed_valid0: got %0b expected 0", valid); end
        pwm[5] = 1'b1;
        step(5);
        do_read(5);
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL first_rise_valid: got %0b expected 0", valid); end
        checks++; if (new_flags[5] !== 1'b0) begin errors++; $display("FAIL first_rise_newflag: got %0b expected 0", new_flags[5]); end
        pwm[5] = 1'b0;
        step(2);
    endtask

    task automatic test_steady();
        ch_result_t exp;
        exp = '{ton: 10'd30, period: 10'd100, valid: 1'b1, stuck: 1'b0};
        pwm[0] = 1'b1; step(30);
        pwm[0] = 1'b0; step(70);
        pwm[0] = 1'b1; step(2);
        checks++; if (new_flags[0] !== 1'b0) begin errors++; $display("FAIL steady_flag_early: got %0b expected 0", new_flags[0]); end
        step(1);
        checks++; if (new_flags[0] !== 1'b1) begin errors++; $display("FAIL steady_flag_set: got %0b expected 1", new_flags[0]); end
        // Out-of-range select loads zeros and clears nothing.
        do_read(24);
        checks++; if (ton_out !== 10'd0 || period_out !== 10'd0 || valid !== 1'b0) begin errors++; $display("FAIL sel_oob_zero: got ton=%0d period=%0d valid=%0b expected 0 0 0", ton_out, period_out, valid); end
        checks++; if (new_flags[0] !== 1'b1) begin errors++; $display("FAIL sel_oob_keep_flag: got %0b expected 1", new_flags[0]); end
        do_read(0);
        checks++; if (ton_out !== exp.ton) begin errors++; $display("FAIL steady_ton: got %0d expected %0d", ton_out, exp.ton); end
        checks++; if (period_out !== exp.period) begin errors++; $display("FAIL steady_period: got %0d expected %0d", period_out, exp.period); end
        checks++; if (valid !== exp.valid || stuck !== exp.stuck) begin errors++; $display("FAIL steady_vs: got valid=%0b stuck=%0b expected 1 0", valid, stuck); end
        checks++; if (new_flags[0] !== 1'b0) begin errors++; $display("FAIL steady_flag_clear: got %0b expected 0", new_flags[0]); end
        pwm[0] = 1'b0;
    endtask

    task automatic test_back_to_back();
        sel = 5'd0; rd = 1'b1; step(1);
        checks++; if (ton_out !== 10'd30 || period_out !== 10'd100) begin errors++; $display("FAIL b2b_first: got ton=%0d period=%0d expected 30 100", ton_out, period_out); end
        sel = 5'd31; step(1);
        checks++; if (ton_out !== 10'd0 || valid !== 1'b0) begin errors++; $display("FAIL b2b_oob: got ton=%0d valid=%0b expected 0 0", ton_out, valid); end
        sel = 5'd0; step(1);
        rd = 1'b0;
        checks++; if (ton_out !== 10'd30 || period_out !== 10'd100 || valid !== 1'b1) begin errors++; $display("FAIL b2b_third: got ton=%0d period=%0d valid=%0b expected 30 100 1", ton_out, period_out, valid); end
        step(1);
        checks++; if (ton_out !== 10'd30) begin errors++; $display("FAIL hold_no_strobe: got %0d expected 30", ton_out); end
    endtask

    task automatic test_saturation();
        pwm[1] = 1'b1; step(500);
        pwm[1] = 1'b0; step(1500);
        pwm[1] = 1'b1; step(3);
        checks++; if (new_flags[1] !== 1'b1) begin errors++; $display("FAIL sat_flag: got %0b expected 1", new_flags[1]); end
        do_read(1);
        checks++; if (period_out !== 10'd1023) begin errors++; $display("FAIL sat_period: got %0d expected 1023", period_out); end
`ifdef PWM_CAPTURE_TIMEOUT_EN
        // The low phase stalls past full scale, so the timeout commit wins.
        checks++; if (ton_out !== 10'd0 || stuck !== 1'b1) begin errors++; $display("FAIL sat_ton: got ton=%0d stuck=%0b expected 0 1", ton_out, stuck); end
`else
        checks++; if (ton_out !== 10'd500 || stuck !== 1'b0) begin errors++; $display("FAIL sat_ton: got ton=%0d stuck=%0b expected 500 0", ton_out, stuck); end
`endif
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL sat_valid: got %0b expected 1", valid); end
        pwm[1] = 1'b0;
    endtask

    task automatic test_stuck_high();
        pwm[2] = 1'b1; step(10);
        pwm[2] = 1'b0; step(10);
        pwm[2] = 1'b1; step(3);
        do_read(2);
        checks++; if (ton_out !== 10'd10 || period_out !== 10'd20) begin errors++; $display("FAIL stuck_pre: got ton=%0d period=%0d expected 10 20", ton_out, period_out); end
        step(1500);
`ifdef PWM_CAPTURE_TIMEOUT_EN
        checks++; if (new_flags[2] !== 1'b1) begin errors++; $display("FAIL stuck_flag: got %0b expected 1", new_flags[2]); end
        do_read(2);
        checks++; if (ton_out !== 10'd1023 || period_out !== 10'd1023 || stuck !== 1'b1 || valid !== 1'b1) begin errors++; $display("FAIL stuck_result: got ton=%0d period=%0d stuck=%0b valid=%0b expected 1023 1023 1 1", ton_out, period_out, stuck, valid); end
        step(200);
        checks++; if (new_flags[2] !== 1'b0) begin errors++; $display("FAIL stuck_single: got %0b expected 0", new_flags[2]); end
`else
        checks++; if (new_flags[2] !== 1'b0) begin errors++; $display("FAIL stuck_flag: got %0b expected 0", new_flags[2]); end
        do_read(2);
        checks++; if (ton_out !== 10'd10 || period_out !== 10'd20 || stuck !== 1'b0) begin errors++; $display("FAIL stuck_hold: got ton=%0d period=%0d stuck=%0b expected 10 20 0", ton_out, period_out, stuck); end
`endif
        pwm[2] = 1'b0;
    endtask

    task automatic test_read_commit_race();
        pwm[3] = 1'b1; step(20);
        pwm[3] = 1'b0; step(20);
        pwm[3] = 1'b1; step(3);
        do_read(3);
        checks++; if (ton_out !== 10'd20 || period_out !== 10'd40) begin errors++; $display("FAIL race_first: got ton=%0d period=%0d expected 20 40", ton_out, period_out); end
        step(11);
        pwm[3] = 1'b0; step(35);
        // Strobe lands on the same edge as the commit of this rise.
        pwm[3] = 1'b1; step(2);
        sel = 5'd3; rd = 1'b1; step(1); rd = 1'b0;
        checks++; if (new_flags[3] !== 1'b1) begin errors++; $display("FAIL race_flag: got %0b expected 1", new_flags[3]); end
        checks++; if (ton_out !== 10'd20 || period_out !== 10'd40) begin errors++; $display("FAIL race_old: got ton=%0d period=%0d expected 20 40", ton_out, period_out); end
        do_read(3);
        checks++; if (ton_out !== 10'd15 || period_out !== 10'd50 || new_flags[3] !== 1'b0) begin errors++; $display("FAIL race_new: got ton=%0d period=%0d flag=%0b expected 15 50 0", ton_out, period_out, new_flags[3]); end
        pwm[3] = 1'b0;
    endtask

    task automatic test_mid_reset();
        pwm[4] = 1'b1; step(10);
        pwm[4] = 1'b0; step(10);
        pwm[4] = 1'b1; step(3);
        do_read(4);
        step(5);
        n_reset = 1'b0;
        pwm[4] = 1'b0;
        step(1);
        checks++; if (ton_out !== 10'd0 || period_out !== 10'd0 || valid !== 1'b0 || new_flags !== 24'h0) begin errors++; $display("FAIL midrst_clear: got ton=%0d period=%0d valid=%0b flags=%06h expected all 0", ton_out, period_out, valid, new_flags); end
        step(2);
        n_reset = 1'b1;
        step(5);
        pwm[4] = 1'b1; step(3);
        checks++; if (new_flags[4] !== 1'b0) begin errors++; $display("FAIL midrst_first_rise: got %0b expected 0", new_flags[4]); end
        step(9);
        pwm[4] = 1'b0; step(13);
        pwm[4] = 1'b1; step(3);
        checks++; if (new_flags[4] !== 1'b1) begin errors++; $display("FAIL midrst_second_rise: got %0b expected 1", new_flags[4]); end
        do_read(4);
        checks++; if (ton_out !== 10'd12 || period_out !== 10'd25 || valid !== 1'b1 || stuck !== 1'b0) begin errors++; $display("FAIL midrst_result: got ton=%0d period=%0d valid=%0b stuck=%0b expected 12 25 1 0", ton_out, period_out, valid, stuck); end
        pwm[4] = 1'b0;
    endtask

    initial begin
        test_reset();
        test_unarmed();
        test_steady();
        test_back_to_back();
        test_saturation();
        test_stuck_high();
        test_read_commit_race();
        test_mid_reset();
        step(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Multi-channel PWM capture block, the measurement counterpart of the team's multi-channel PWM generator. It samples NB_CH asynchronous PWM inputs and measures each channel's high time and period in ClkIn cycles. Each completed measurement is committed to per-channel registers, which a host or loopback checker reads one channel at a time. Its main use is closed-loop verification of generated PWM and capture of external PWM sensors.

## Interface
- NB_CH, 24, number of capture channels
- RESOLUTION, 10, counter and result width in bits; full scale is 2^RESOLUTION-1
- SEL_W, $clog2(NB_CH), width of the channel select
- ClkIn  in  1  system clock; all logic on rising edge
- nReset  in  1  synchronous, active-low reset
- PWMin  in  NB_CH  asynchronous PWM inputs
- Sel  in  SEL_W  channel to read
- RdStrobe  in  1  one-cycle read request for channel Sel
- TonOut  out  RESOLUTION  high time of the read channel, in cycles
- PeriodOut  out  RESOLUTION  period of the read channel, in cycles
- Valid  out  1  read channel has committed at least one measurement
- Stuck  out  1  read channel's last commit came from timeout
- NewFlags  out  NB_CH  per channel: a commit has occurred since the last read

## Operation
- Input synchronization, per channel: s1 <= PWMin, s2 <= s1, s3 <= s2.
  - rise = s2 & ~s3
  - fall = ~s2 & s3
- Counter cnt (RESOLUTION bits), per channel:
  - on a rise cycle: cnt <= 1
  - otherwise: cnt <= cnt+1, saturating at 2^RESOLUTION-1
- On a fall cycle: tonPend <= cnt.
- On a rise cycle:
  - if armed=1: Ton <= tonPend, Period <= cnt, Stuck <= 0, Valid <= 1, New <= 1.
  - always: armed <= 1.
  - The first rise after reset only arms the channel and commits nothing.
- Saturation: a saturated cnt is committed as 2^RESOLUTION-1. No wrap-around occurs.
- Example: a steady signal with a period of P cycles and H high cycles commits Period=P and Ton=H.
- Read path:
  - On a RdStrobe cycle, the output registers load the channel[Sel] values and New[Sel] is cleared.
  - If the same channel commits in the same cycle, the commit wins: New stays 1, and the outputs show the pre-commit values.
  - Without RdStrobe, the outputs hold.
  - If Sel >= NB_CH, the outputs load zeros and no flag is cleared.
- Reset values: every register is 0, including all outputs, NewFlags, armed and tonPend. Asserting reset mid-period discards the partial measurement.

## Timing
- A PWMin edge that is first sampled at clock edge N produces its rise/fall cycle between N+1 and N+2. The channel registers and NewFlags update at edge N+2.
- Read latency is 1 cycle: RdStrobe at edge M gives outputs valid after edge M+1.
- RdStrobe may be asserted every cycle.
- Minimum measurable pulse width is 1 cycle high or low after synchronization. Narrower glitches are missed.

## Configuration
- PWM_CAPTURE_TIMEOUT_EN defined:
  - When cnt reaches 2^RESOLUTION-1 with no rise, the channel commits Period=2^RESOLUTION-1.
  - Ton is 2^RESOLUTION-1 if s2=1, or 0 if s2=0.
  - The commit sets Stuck=1, Valid=1 and New=1, and also sets armed <= 0.
  - Only one timeout commit occurs per stall. The next rise re-arms the channel.
- PWM_CAPTURE_TIMEOUT_EN undefined:
  - No timeout commit occurs, and the last values hold indefinitely.
  - Stuck is tied to 0.

## Structure
- Shared package pwm_capture_pkg holds:
  - default RESOLUTION and NB_CH
  - the full-scale constant CNT_MAX
  - a struct typedef for one channel's result {ton, period, valid, stuck}
- Sub-module pwm_capture_ch contains one channel: synchronizer, edge detect, counter, armed/pending logic and result register. It is instantiated NB_CH times in a generate loop.
- The top level contains the read mux, the output registers and NewFlags clearing.

## Test plan
- All tests use RESOLUTION=10.
- Steady PWM on ch0, period 100, high 30. After the second rise: NewFlags[0]=1. Then Sel=0 with RdStrobe gives TonOut=30, PeriodOut=100, Valid=1, Stuck=0, and NewFlags[0]=0 the following cycle.
- Read ch5 before any edge -> all outputs 0, Valid=0. Apply one rise only, then read -> still Valid=0, because the first rise only arms the channel.
- Period 2000 on ch1 -> PeriodOut=1023 (saturated) and a correct Ton if Ton < 1023.
- ch2 held high for 1500 cycles after an armed rise:
  - with PWM_CAPTURE_TIMEOUT_EN: a single commit with Ton=1023, Period=1023, Stuck=1.
  - without it: no NewFlags[2] activity.
- RdStrobe on ch3 in the same cycle as a ch3 commit -> NewFlags[3] remains 1, and the outputs show the previous measurement. The next read shows the new one.
- Reset asserted mid-period on ch4 -> all outputs and NewFlags are 0 the cycle after. The first post-reset rise does not commit; the commit after the second rise is correct.
